priority_table: RTL and testbench
=================================

Name: priority_table

Overview:
- Parametrised, run-time-reconfigurable priority store for the intersection controller. Replaces the fixed four-way priority assignment.
- Holds one rank per channel (pedestrian, up, down, turn, ... generalised to N). The ranks always form a permutation of 0..N-1; rank 0 is the highest priority.
- Accepts promote / demote / rotate / load commands over a valid/ready handshake. Updates are applied sequentially, one channel per cycle.
- Continuously self-checks the permutation invariant and raises a sticky fault if it is ever violated.

Parameters:
- N, 4, number of channels; legal range 2..16.
- W, $clog2(N), rank and channel-index width. Derived; do not override.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block is idle and accepts a command this cycle
- cmd_op  in  2  00 PROMOTE, 01 DEMOTE, 10 ROTATE, 11 LOAD
- cmd_chan  in  W  target channel for PROMOTE and DEMOTE
- load_flat  in  N*W  candidate table for LOAD; channel i occupies bits [i*W +: W]
- done  out  1  one-cycle pulse when a command completes
- cmd_err  out  1  valid only with done; 1 = command rejected, table unchanged
- rank_flat  out  N*W  current rank of each channel, same packing as load_flat
- rank_valid  out  1  rank_flat is a consistent permutation (low during an update)
- top_chan  out  W  channel whose rank is 0; registered
- perm_fault  out  1  sticky integrity fault

Behaviour:
- Reset is synchronous, active-low, on clock, named reset. Reset values:
  - rank[i] = i; top_chan = 0
  - state = IDLE; cmd_ready = 1; rank_valid = 1
  - done = 0; cmd_err = 0; perm_fault = 0
- Reset asserted mid-UPDATE aborts the command. The table returns to identity and no done pulse is produced.
- States: IDLE, UPDATE.
- cmd_ready = (state == IDLE). Handshake occurs when cmd_valid && cmd_ready. cmd_valid while busy is ignored; nothing is queued.
- On accepting PROMOTE or DEMOTE (cycle T):
  - If cmd_chan >= N: reject. done = 1 and cmd_err = 1 in cycle T+1; no state change.
  - Otherwise: latch op, chan and r = rank[chan]. Go to UPDATE with index i = 0; rank_valid drops to 0 from T+1.
- On accepting ROTATE: latch op and go to UPDATE with i = 0.
- UPDATE processes channel i on each clock edge, for i = 0..N-1 (N cycles):
  - PROMOTE: if i == chan, rank = 0; else if rank[i] < r, rank[i] + 1; else unchanged.
  - DEMOTE: if i == chan, rank = N-1; else if rank[i] > r, rank[i] - 1; else unchanged.
  - ROTATE: rank[i] = (rank[i] == N-1) ? 0 : rank[i] + 1. Explicit wrap; N need not be a power of two.
- Timing after the update, for accept at cycle T:
  - Last write occurs on the edge ending cycle T+N.
  - Cycle T+N+1: state = IDLE, done = 1, cmd_err = 0, rank_valid = 1, top_chan updated.
  - A new command may be accepted in cycle T+N+1.
- PROMOTE of a channel already at rank 0, or DEMOTE of one at rank N-1, still takes N cycles and leaves the table unchanged.
- LOAD is single-cycle, accepted at cycle T:
  - load_flat is checked combinationally: every entry < N and every value 0..N-1 present exactly once.
  - If legal: the table is written at the end of cycle T.
  - If illegal: the table is untouched.
  - Cycle T+1: done = 1; cmd_err = !legal.
- top_chan is recomputed from the table whenever the block is in IDLE: lowest index with rank == 0.
- perm_fault:
  - Evaluated every IDLE cycle after reset.
  - Set if the table is not a permutation; cleared only by reset.
  - Never evaluated during UPDATE, where the table is transiently inconsistent.
- done and cmd_err are registered. Both are 0 in every cycle other than the completion cycle.

Test Plan:
- N=4, after reset: PROMOTE chan 2 accepted at T -> cycle T+5 done=1, cmd_err=0, rank_flat {ch0..3} = {1,2,0,3}, top_chan=2, rank_valid low in T+1..T+4.
- From {1,2,0,3}: DEMOTE chan 0 -> {3,1,0,2}; cmd_valid held high during UPDATE is not accepted until cmd_ready=1.
- N=3, after reset: ROTATE -> {1,2,0}, top_chan=2; second ROTATE -> {2,0,1}, top_chan=1.
- N=4: LOAD {0,0,1,2} -> done with cmd_err=1, table stays {0,1,2,3}. LOAD {3,2,1,0} -> cmd_err=0, top_chan=3. perm_fault stays 0 throughout.
- N=4: PROMOTE with cmd_chan=5 (4'b... out of range, W=2 so use N=5, chan=6) -> cmd_err=1 next cycle, table unchanged.
- Reset asserted (low) at cycle T+2 of a PROMOTE -> next cycle table = identity, cmd_ready=1, no done pulse, perm_fault=0.

Source files
------------

// File: rtl/priority_table_if.sv
// Command/status bundle for the priority table: the master issues commands,
// the slave (priority_table) reports completion and the current rank table.
interface priority_table_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) ();
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [W-1:0]   cmd_chan;
    logic [N*W-1:0] load_flat;
    logic           done;
    logic           cmd_err;
    logic [N*W-1:0] rank_flat;
    logic           rank_valid;
    logic [W-1:0]   top_chan;
    logic           perm_fault;

    modport master (
        output cmd_valid, cmd_op, cmd_chan, load_flat,
        input  cmd_ready, done, cmd_err, rank_flat, rank_valid, top_chan, perm_fault
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_chan, load_flat,
        output cmd_ready, done, cmd_err, rank_flat, rank_valid, top_chan, perm_fault
    );
endinterface

// File: rtl/priority_table.sv
// Run-time reconfigurable per-channel priority ranks (always a permutation of
// 0..N-1), updated one channel per cycle, with a sticky permutation self-check.
module priority_table #(
    parameter int unsigned N = 4,
    parameter int unsigned W = $clog2(N)
) (
    input  logic              clock,
    input  logic              reset,
    priority_table_if.slave   bus
);

    typedef enum logic {
        S_IDLE,
        S_UPDATE
    } state_e;

    typedef enum logic [1:0] {
        OP_PROMOTE = 2'b00,
        OP_DEMOTE  = 2'b01,
        OP_ROTATE  = 2'b10,
        OP_LOAD    = 2'b11
    } op_e;

    localparam logic [W-1:0] LAST = W'(N - 1);

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [W-1:0]   chan_q, chan_d;
    logic [W-1:0]   r_q, r_d;
    logic [W-1:0]   idx_q, idx_d;
    logic [W-1:0]   top_q, top_d;
    logic [W-1:0]   rank_q [N];
    logic [W-1:0]   rank_d [N];
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           fault_q, fault_d;
    logic           ready_q, ready_d;
    logic           rv_q, rv_d;
    logic [N*W-1:0] table_flat;
    logic           load_legal;
    logic           chan_oor;

    // True when every entry is < N and no value repeats, i.e. a permutation.
    function automatic logic is_perm(input logic [N*W-1:0] flat);
        logic [N-1:0] seen;
        logic         ok;
        logic [W-1:0] e;
        seen = '0;
        ok   = 1'b1;
        for (int i = 0; i < N; i++) begin
            e = flat[i*W +: W];
            if ({1'b0, e} >= (W+1)'(N)) ok = 1'b0;
            for (int v = 0; v < N; v++) begin
                if (e == W'(v)) begin
                    if (seen[v]) ok = 1'b0;
                    seen[v] = 1'b1;
                end
            end
        end
        return ok;
    endfunction

    always_comb begin
        table_flat = '0;
        for (int i = 0; i < N; i++) table_flat[i*W +: W] = rank_q[i];
    end

    assign load_legal = is_perm(bus.load_flat);
    assign chan_oor   = {1'b0, bus.cmd_chan} >= (W+1)'(N);

    // Next-state, table update and completion flags.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        chan_d  = chan_q;
        r_d     = r_q;
        idx_d   = idx_q;
        rank_d  = rank_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        top_d   = top_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    unique case (op_e'(bus.cmd_op))
                        OP_PROMOTE, OP_DEMOTE: begin
                            if (chan_oor) begin
                                done_d = 1'b1;
                                err_d  = 1'b1;
                            end else begin
                                op_d    = op_e'(bus.cmd_op);
                                chan_d  = bus.cmd_chan;
                                r_d     = rank_q[bus.cmd_chan];
                                idx_d   = '0;
                                state_d = S_UPDATE;
                            end
                        end
                        OP_ROTATE: begin
                            op_d    = OP_ROTATE;
                            idx_d   = '0;
                            state_d = S_UPDATE;
                        end
                        OP_LOAD: begin
                            if (load_legal) begin
                                for (int i = 0; i < N; i++) rank_d[i] = bus.load_flat[i*W +: W];
                            end
                            done_d = 1'b1;
                            err_d  = !load_legal;
                        end
                        default: ;
                    endcase
                end
            end
            S_UPDATE: begin
                for (int i = 0; i < N; i++) begin
                    if (idx_q == W'(i)) begin
                        unique case (op_q)
                            OP_PROMOTE: begin
                                if (W'(i) == chan_q)    rank_d[i] = '0;
                                else if (rank_q[i] < r_q) rank_d[i] = rank_q[i] + W'(1);
                            end
                            OP_DEMOTE: begin
                                if (W'(i) == chan_q)    rank_d[i] = LAST;
                                else if (rank_q[i] > r_q) rank_d[i] = rank_q[i] - W'(1);
                            end
                            OP_ROTATE: rank_d[i] = (rank_q[i] == LAST) ? '0 : rank_q[i] + W'(1);
                            default: ;
                        endcase
                    end
                end
                if (idx_q == LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // top_chan tracks the table that will be visible next cycle.
        if (state_d == S_IDLE) begin
            top_d = '0;
            for (int i = N - 1; i >= 0; i--) begin
                if (rank_d[i] == '0) top_d = W'(i);
            end
        end

        ready_d = (state_d == S_IDLE);
        rv_d    = (state_d == S_IDLE);
        fault_d = fault_q | ((state_q == S_IDLE) && !is_perm(table_flat));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_PROMOTE;
            chan_q  <= '0;
            r_q     <= '0;
            idx_q   <= '0;
            top_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fault_q <= 1'b0;
            ready_q <= 1'b1;
            rv_q    <= 1'b1;
            for (int i = 0; i < N; i++) rank_q[i] <= W'(i);
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            chan_q  <= chan_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            top_q   <= top_d;
            done_q  <= done_d;
            err_q   <= err_d;
            fault_q <= fault_d;
            ready_q <= ready_d;
            rv_q    <= rv_d;
            for (int i = 0; i < N; i++) rank_q[i] <= rank_d[i];
        end
    end

    assign bus.cmd_ready  = ready_q;
    assign bus.done       = done_q;
    assign bus.cmd_err    = err_q;
    assign bus.rank_flat  = table_flat;
    assign bus.rank_valid = rv_q;
    assign bus.top_chan   = top_q;
    assign bus.perm_fault = fault_q;

endmodule

// File: tb/tb_priority_table.sv
// Directed bench for priority_table: three instances (N=4, N=3, N=5) driven
// by one linear step sequence, expected values worked out by hand.
module tb_priority_table;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    priority_table_if #(.N(4)) if4 ();
    priority_table_if #(.N(3)) if3 ();
    priority_table_if #(.N(5)) if5 ();

    priority_table #(.N(4)) u4 (.clock(clock), .reset(reset), .bus(if4));
    priority_table #(.N(3)) u3 (.clock(clock), .reset(reset), .bus(if3));
    priority_table #(.N(5)) u5 (.clock(clock), .reset(reset), .bus(if5));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        if4.cmd_valid = 1'b0; if4.cmd_op = 2'b00; if4.cmd_chan = '0; if4.load_flat = '0;
        if3.cmd_valid = 1'b0; if3.cmd_op = 2'b00; if3.cmd_chan = '0; if3.load_flat = '0;
        if5.cmd_valid = 1'b0; if5.cmd_op = 2'b00; if5.cmd_chan = '0; if5.load_flat = '0;
        cyc(2);
        reset = 1'b1;

        // Reset state
        chk("rst_rank4", 64'(if4.rank_flat), 64'({2'd3, 2'd2, 2'd1, 2'd0}));
        chk("rst_ready", 64'(if4.cmd_ready), 64'd1);
        chk("rst_rv",    64'(if4.rank_valid), 64'd1);
        chk("rst_done",  64'(if4.done), 64'd0);
        chk("rst_err",   64'(if4.cmd_err), 64'd0);
        chk("rst_top",   64'(if4.top_chan), 64'd0);
        chk("rst_fault", 64'(if4.perm_fault), 64'd0);
        chk("rst_rank3", 64'(if3.rank_flat), 64'({2'd2, 2'd1, 2'd0}));
        chk("rst_rank5", 64'(if5.rank_flat), 64'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));

        // PROMOTE ch2 from identity -> ranks ch0..3 = {1,2,0,3}
        if4.cmd_valid = 1'b1; if4.cmd_op = 2'b00; if4.cmd_chan = 2'd2;
        cyc(1);
        if4.cmd_valid = 1'b0;
        chk("pro_busy_ready", 64'(if4.cmd_ready), 64'd0);
        chk("pro_rv_t1",   64'(if4.rank_valid), 64'd0);
        chk("pro_done_t1", 64'(if4.done), 64'd0);
        for (int k = 2; k <= 4; k++) begin
            cyc(1);
            chk("pro_rv_busy",   64'(if4.rank_valid), 64'd0);
            chk("pro_done_busy", 64'(if4.done), 64'd0);
        end
        cyc(1);
        chk("pro_done",  64'(if4.done), 64'd1);
        chk("pro_err",   64'(if4.cmd_err), 64'd0);
        chk("pro_rank",  64'(if4.rank_flat), 64'({2'd3, 2'd0, 2'd2, 2'd1}));
        chk("pro_top",   64'(if4.top_chan), 64'd2);
        chk("pro_rv",    64'(if4.rank_valid), 64'd1);
        chk("pro_ready", 64'(if4.cmd_ready), 64'd1);

        // DEMOTE ch0 -> {3,1,0,2}; a PROMOTE ch3 held valid during the update
        if4.cmd_valid = 1'b1; if4.cmd_op = 2'b01; if4.cmd_chan = 2'd0;
        cyc(1);
        if4.cmd_op = 2'b00; if4.cmd_chan = 2'd3;
        chk("dem_ready_t1", 64'(if4.cmd_ready), 64'd0);
        chk("dem_done_t1",  64'(if4.done), 64'd0);
        cyc(3);
        chk("dem_done_t4", 64'(if4.done), 64'd0);
        chk("dem_rv_t4",   64'(if4.rank_valid), 64'd0);
        cyc(1);
        chk("dem_done", 64'(if4.done), 64'd1);
        chk("dem_err",  64'(if4.cmd_err), 64'd0);
        chk("dem_rank", 64'(if4.rank_flat), 64'({2'd2, 2'd0, 2'd1, 2'd3}));
        chk("dem_top",  64'(if4.top_chan), 64'd2);
        // the held PROMOTE ch3 is taken in this cycle: {3,1,0,2} -> {3,2,1,0}
        cyc(1);
        if4.cmd_valid = 1'b0;
        chk("held_accepted", 64'(if4.cmd_ready), 64'd0);
        chk("held_done_t1",  64'(if4.done), 64'd0);
        cyc(4);
        chk("held_done", 64'(if4.done), 64'd1);
        chk("held_rank", 64'(if4.rank_flat), 64'({2'd0, 2'd1, 2'd2, 2'd3}));
        chk("held_top",  64'(if4.top_chan), 64'd3);
        cyc(1);
        chk("held_pulse", 64'(if4.done), 64'd0);

        // LOAD tests from identity
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        chk("ld_rst_rank", 64'(if4.rank_flat), 64'({2'd3, 2'd2, 2'd1, 2'd0}));
        if4.cmd_valid = 1'b1; if4.cmd_op = 2'b11;
        if4.load_flat = {2'd2, 2'd1, 2'd0, 2'd0};
        cyc(1);
        if4.cmd_valid = 1'b0;
        chk("ld_bad_done",  64'(if4.done), 64'd1);
        chk("ld_bad_err",   64'(if4.cmd_err), 64'd1);
        chk("ld_bad_rank",  64'(if4.rank_flat), 64'({2'd3, 2'd2, 2'd1, 2'd0}));
        chk("ld_bad_ready", 64'(if4.cmd_ready), 64'd1);
        if4.cmd_valid = 1'b1;
        if4.load_flat = {2'd0, 2'd1, 2'd2, 2'd3};
        cyc(1);
        if4.cmd_valid = 1'b0;
        chk("ld_ok_done", 64'(if4.done), 64'd1);
        chk("ld_ok_err",  64'(if4.cmd_err), 64'd0);
        chk("ld_ok_rank", 64'(if4.rank_flat), 64'({2'd0, 2'd1, 2'd2, 2'd3}));
        chk("ld_ok_top",  64'(if4.top_chan), 64'd3);
        chk("ld_ok_rv",   64'(if4.rank_valid), 64'd1);
        cyc(1);
        chk("ld_pulse_done", 64'(if4.done), 64'd0);
        chk("ld_pulse_err",  64'(if4.cmd_err), 64'd0);
        chk("ld_fault",      64'(if4.perm_fault), 64'd0);

        // N=3 ROTATE twice: {0,1,2} -> {1,2,0} -> {2,0,1}
        if3.cmd_valid = 1'b1; if3.cmd_op = 2'b10;
        cyc(1);
        if3.cmd_valid = 1'b0;
        cyc(2);
        chk("rot1_done_t3", 64'(if3.done), 64'd0);
        chk("rot1_rv_t3",   64'(if3.rank_valid), 64'd0);
        cyc(1);
        chk("rot1_done", 64'(if3.done), 64'd1);
        chk("rot1_rank", 64'(if3.rank_flat), 64'({2'd0, 2'd2, 2'd1}));
        chk("rot1_top",  64'(if3.top_chan), 64'd2);
        if3.cmd_valid = 1'b1;
        cyc(1);
        if3.cmd_valid = 1'b0;
        cyc(3);
        chk("rot2_done", 64'(if3.done), 64'd1);
        chk("rot2_rank", 64'(if3.rank_flat), 64'({2'd1, 2'd0, 2'd2}));
        chk("rot2_top",  64'(if3.top_chan), 64'd1);

        // DEMOTE of the channel already at rank N-1 leaves the table alone
        if3.cmd_valid = 1'b1; if3.cmd_op = 2'b01; if3.cmd_chan = 2'd0;
        cyc(1);
        if3.cmd_valid = 1'b0;
        cyc(2);
        chk("demlast_done_t3", 64'(if3.done), 64'd0);
        cyc(1);
        chk("demlast_done", 64'(if3.done), 64'd1);
        chk("demlast_err",  64'(if3.cmd_err), 64'd0);
        chk("demlast_rank", 64'(if3.rank_flat), 64'({2'd1, 2'd0, 2'd2}));
        chk("demlast_fault", 64'(if3.perm_fault), 64'd0);

        // N=5: out-of-range channel and illegal/legal LOADs
        if5.cmd_valid = 1'b1; if5.cmd_op = 2'b00; if5.cmd_chan = 3'd6;
        cyc(1);
        if5.cmd_valid = 1'b0;
        chk("oor_done",  64'(if5.done), 64'd1);
        chk("oor_err",   64'(if5.cmd_err), 64'd1);
        chk("oor_ready", 64'(if5.cmd_ready), 64'd1);
        chk("oor_rank",  64'(if5.rank_flat), 64'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
        cyc(1);
        chk("oor_pulse", 64'(if5.done), 64'd0);
        if5.cmd_valid = 1'b1; if5.cmd_op = 2'b11;
        if5.load_flat = {3'd4, 3'd3, 3'd2, 3'd1, 3'd7};
        cyc(1);
        if5.cmd_valid = 1'b0;
        chk("ld5_bad_err",  64'(if5.cmd_err), 64'd1);
        chk("ld5_bad_rank", 64'(if5.rank_flat), 64'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
        if5.cmd_valid = 1'b1;
        if5.load_flat = {3'd2, 3'd1, 3'd3, 3'd0, 3'd4};
        cyc(1);
        if5.cmd_valid = 1'b0;
        chk("ld5_ok_done", 64'(if5.done), 64'd1);
        chk("ld5_ok_err",  64'(if5.cmd_err), 64'd0);
        chk("ld5_ok_rank", 64'(if5.rank_flat), 64'({3'd2, 3'd1, 3'd3, 3'd0, 3'd4}));
        chk("ld5_ok_top",  64'(if5.top_chan), 64'd1);
        cyc(1);
        chk("ld5_fault", 64'(if5.perm_fault), 64'd0);

        // Reset during a PROMOTE aborts it: identity, idle, no done pulse
        if4.cmd_valid = 1'b1; if4.cmd_op = 2'b00; if4.cmd_chan = 2'd1;
        cyc(1);
        if4.cmd_valid = 1'b0;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        chk("abort_rank",  64'(if4.rank_flat), 64'({2'd3, 2'd2, 2'd1, 2'd0}));
        chk("abort_ready", 64'(if4.cmd_ready), 64'd1);
        chk("abort_rv",    64'(if4.rank_valid), 64'd1);
        chk("abort_top",   64'(if4.top_chan), 64'd0);
        chk("abort_fault", 64'(if4.perm_fault), 64'd0);
        for (int k = 0; k < 6; k++) begin
            chk("abort_no_done", 64'(if4.done), 64'd0);
            cyc(1);
        end
        chk("abort_rank_hold", 64'(if4.rank_flat), 64'({2'd3, 2'd2, 2'd1, 2'd0}));
        chk("end_fault4", 64'(if4.perm_fault), 64'd0);
        chk("end_fault3", 64'(if3.perm_fault), 64'd0);
        chk("end_fault5", 64'(if5.perm_fault), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
